// File: rtl/flght_pkg.sv
// Shared types and constants for the flight sequencer.
package flght_pkg;
    localparam int THRST_W = 9;
    localparam int TMR_W   = 24;

    localparam logic [TMR_W-1:0] CAL_TIMEOUT_DEF = 24'hFF_FFFF;
    localparam logic [7:0]       RAMP_DIV_DEF    = 8'd64;
    localparam logic [TMR_W-1:0] VLD_TIMEOUT_DEF = 24'h20_0000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAL     = 3'd1,
        S_ARM     = 3'd2,
        S_FLY     = 3'd3,
        S_RAMP_DN = 3'd4,
        S_FAULT   = 3'd5
    } seq_state_t;
endpackage

// File: rtl/flght_seq_thrst_ramp.sv
// Thrust ramp register with a divide-by-RAMP_DIV step prescaler; saturates at both ends.
module thrst_ramp
    import flght_pkg::*;
#(
    parameter logic [7:0] RAMP_DIV = RAMP_DIV_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up,
    input  logic               dn,
    input  logic               load,
    input  logic [THRST_W-1:0] load_val,
    input  logic               clr,
    output logic [THRST_W-1:0] thrst,
    output logic               at_zero,
    output logic               step
);
    localparam logic [7:0] DIV_M1 = RAMP_DIV - 8'd1;

    logic [7:0]         presc_q, presc_d;
    logic [THRST_W-1:0] thrst_q, thrst_d;

    assign step    = (up | dn) && (presc_q == DIV_M1);
    assign thrst   = thrst_q;
    assign at_zero = (thrst_q == '0);

    always_comb begin
        presc_d = presc_q;
        if (clr)
            presc_d = '0;
        else if (up | dn)
            presc_d = step ? 8'd0 : presc_q + 8'd1;

        // A load overrides any ramp step in the same cycle.
        thrst_d = thrst_q;
        if (load)
            thrst_d = load_val;
        else if (step && up && thrst_q != '1)
            thrst_d = thrst_q + THRST_W'(1);
        else if (step && dn && thrst_q != '0)
            thrst_d = thrst_q - THRST_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            thrst_q <= '0;
        end else begin
            presc_q <= presc_d;
            thrst_q <= thrst_d;
        end
    end
endmodule

// File: rtl/flght_seq.sv
// Flight sequencer: calibration, thrust ramp-up, flight, ramp-down, with a vld watchdog.
module flght_seq
    import flght_pkg::*;
#(
    parameter logic [TMR_W-1:0] CAL_TIMEOUT = CAL_TIMEOUT_DEF,
    parameter logic [7:0]       RAMP_DIV    = RAMP_DIV_DEF,
    parameter logic [TMR_W-1:0] VLD_TIMEOUT = VLD_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strt_cal,
    input  logic               motors_off,
    input  logic               cal_done,
    input  logic               vld,
    input  logic [THRST_W-1:0] thrst_in,
    output logic               inertial_cal,
    output logic [THRST_W-1:0] thrst_out,
    output logic               mtrs_en,
    output logic               cal_err,
    output logic               vld_lost,
    output logic [2:0]         seq_state
);
    seq_state_t         state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
    logic               cal_err_q, cal_err_d, vld_lost_q, vld_lost_d;
    logic               mtrs_en_q, ical_q;
    logic               r_up, r_dn, r_load, r_clr, r_zero, r_step;
    logic [THRST_W-1:0] r_val, r_thrst, thrst_nxt_up;
    logic               wd_exp;

    thrst_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
        .clk      (clk),
        .rst_n    (rst_n),
        .up       (r_up),
        .dn       (r_dn),
        .load     (r_load),
        .load_val (r_val),
        .clr      (r_clr),
        .thrst    (r_thrst),
        .at_zero  (r_zero),
        .step     (r_step)
    );

    // One timer serves both as the CAL timeout and the ARM/FLY vld watchdog.
    assign tmr_inc      = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
    assign wd_exp       = !vld && (tmr_q == VLD_TIMEOUT - TMR_W'(1));
    assign thrst_nxt_up = (r_step && r_thrst != '1) ? r_thrst + THRST_W'(1) : r_thrst;
    assign r_clr        = (state_d != state_q);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cal_err_d  = cal_err_q;
        vld_lost_d = vld_lost_q;
        r_up       = 1'b0;
        r_dn       = 1'b0;
        r_load     = 1'b0;
        r_val      = '0;
        unique case (state_q)
            S_IDLE, S_FAULT: begin
                r_load = 1'b1;
                if (strt_cal) begin
                    state_d    = S_CAL;
                    tmr_d      = '0;
                    cal_err_d  = 1'b0;
                    vld_lost_d = 1'b0;
                end
            end
            S_CAL: begin
                r_load = 1'b1;
                tmr_d  = tmr_inc;
                if (motors_off) begin
                    state_d = S_IDLE;
                end else if (cal_done) begin
                    state_d = S_ARM;
                    tmr_d   = '0;
                end else if (tmr_q == CAL_TIMEOUT - TMR_W'(1)) begin
                    state_d   = S_FAULT;
                    cal_err_d = 1'b1;
                end
            end
            S_ARM, S_FLY: begin
                r_up  = (state_q == S_ARM);
                tmr_d = vld ? '0 : tmr_inc;
                if (wd_exp) begin
                    state_d    = S_RAMP_DN;
                    vld_lost_d = 1'b1;
                end else if (motors_off) begin
                    state_d = S_RAMP_DN;
                end else if (state_q == S_FLY || thrst_nxt_up >= thrst_in) begin
                    // Ramp target reached (or target lowered below us): snap to it and fly.
                    r_load  = 1'b1;
                    r_val   = thrst_in;
                    state_d = S_FLY;
                end
            end
            S_RAMP_DN: begin
                r_dn = 1'b1;
                if (r_zero || (r_step && r_thrst == THRST_W'(1)))
                    state_d = vld_lost_q ? S_FAULT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            cal_err_q  <= 1'b0;
            vld_lost_q <= 1'b0;
            mtrs_en_q  <= 1'b0;
            ical_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cal_err_q  <= cal_err_d;
            vld_lost_q <= vld_lost_d;
            mtrs_en_q  <= (state_d == S_CAL) || (state_d == S_ARM) ||
                          (state_d == S_FLY) || (state_d == S_RAMP_DN);
            ical_q     <= (state_d == S_CAL);
        end
    end

    assign seq_state    = state_q;
    assign inertial_cal = ical_q;
    assign mtrs_en      = mtrs_en_q;
    assign cal_err      = cal_err_q;
    assign vld_lost     = vld_lost_q;
    assign thrst_out    = r_thrst;
endmodule
